gpgpu_axi_mem_responder: RTL
============================

// Module: gpgpu_axi_mem_responder
// PURPOSE
//  AXI4 burst slave that terminates the GPGPU memory master port on FPGA test builds, backed by on-chip RAM.
//  It accepts the GPGPU's INCR read/write bursts (default 4 beats x 64 bit), stores write data and returns read data with ID echo.
//  It sits between the adapter's m_axi_* master port and nothing else: it is the memory end of that link.
// PARAMETERS
//  ADDR_WIDTH  32      AXI address width
//  DATA_WIDTH  64      beat width; AxSIZE must equal log2(DATA_WIDTH/8)=3
//  ID_WIDTH    4       AWID/ARID width
//  MEM_WORDS   4096    RAM depth in DATA_WIDTH words
//  BASE_ADDR   32'h0   byte address of word 0
// PORTS
//  clock           in   1    single clock, all logic rising-edge
//  reset           in   1    asynchronous, ACTIVE-LOW reset
//  s_axi_aw{valid,ready}/awid/awaddr/awlen[7:0]/awsize[2:0]/awburst[1:0]  AW channel (ready is out)
//  s_axi_w{valid,ready}/wdata/wstrb[DATA_WIDTH/8]/wlast                   W channel (ready is out)
//  s_axi_b{valid,ready}/bid/bresp[1:0]                                    B channel (valid/id/resp out)
//  s_axi_ar{valid,ready}/arid/araddr/arlen/arsize/arburst                 AR channel (ready is out)
//  s_axi_r{valid,ready}/rid/rdata/rresp[1:0]/rlast                        R channel (valid/id/data/resp/last out)
//  awlock/awcache/awprot/awqos, ar equivalents: in, accepted and ignored
// BEHAVIOUR
//  Reset: every output 0; FSMs to IDLE; RAM contents not cleared, and survive reset.
//  All outputs registered. awready/arready rise on the first clock after reset release.
//  Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
//   W_IDLE: awready=1; AW handshake at cycle T latches id/addr/len/size/burst; wready=1 from T+1.
//   W_DATA: each W handshake writes RAM[idx] byte-wise per wstrb; beat counter runs 0..awlen.
//   Next idx: INCR +1; FIXED keeps idx; WRAP treated as INCR.
//   The counted final beat (cnt==awlen) ends the burst, whatever wlast says; then wready=0.
//   W_RESP: bvalid=1 at the cycle after the final beat, with bid=awid. bvalid, bid and bresp hold until bready.
//   awready returns 1 the cycle after the B handshake.
//  Read FSM R_IDLE -> R_DATA -> R_IDLE:
//   AR handshake at T: first beat is on R at T+1 (rvalid=1).
//   Sustains 1 beat per cycle while rready=1.
//   While stalled (rvalid & !rready), rdata, rresp, rlast and rid are held stable.
//   rid=arid on every beat; rlast=1 only on beat arlen. arready returns 1 the cycle after the rlast handshake.
//  Address: idx=(addr-BASE_ADDR)>>log2(DATA_WIDTH/8); the low address bits are ignored.
//  Errors give SLVERR=2'b10 and are otherwise OKAY=2'b00:
//   out-of-range beat (idx>=MEM_WORDS or addr<BASE_ADDR): write suppressed for that beat, rdata=0 for that beat.
//   AxSIZE!=3: whole burst is SLVERR; no RAM writes; rdata=0.
//   wlast mismatch (asserted before the final beat, or missing on it): bresp=SLVERR; data is still written.
//   bresp is sticky-OR over the burst; rresp is per beat.
//  Read and write channels are fully independent and may be active in the same cycle.
//   Same word in the same cycle: the read returns the pre-write value.
//  Only one outstanding burst per direction; no interleaving or reordering.
//  Reset asserted mid-burst: outputs drop to 0 immediately. The partial write already done stays in RAM; no B/R is emitted.
// TESTING
//  1 AW addr 0x100 len 3 id 5, W 0x11..,0x22..,0x33..,0x44.. -> bvalid at last+1, bid 5, bresp 0.
//    AR same addr/id -> 4 beats of same data, rlast on beat 4, rid 5, rresp 0.
//  2 Hold bready=0 for 10 cycles after burst -> bvalid, bid and bresp stable, awready 0; B handshake -> awready 1 next cycle.
//  3 Read burst with rready toggling 1,0,0,1,... -> each beat held stable while stalled; 4 beats in order, none lost or duplicated.
//  4 Write at BASE+MEM_WORDS*8 -> bresp 2'b10, RAM unchanged; awsize=2 -> SLVERR, no writes;
//    wlast on beat 2 of len 3 -> 4 beats still consumed, bresp 2'b10.
//  5 Concurrent write burst to 0x200 and read of 0x200 overlapping beat-for-beat -> each read beat returns the old value; later read returns new data.
//  6 Assert reset mid read (beat 2) -> rvalid 0 immediately.
//    Release -> arready 1 after one clock; earlier-written data still reads back intact.

Source files
------------

// File: rtl/gpgpu_axi_mem_responder.sv
// gpgpu_axi_mem_responder: AXI4 INCR/FIXED burst slave on on-chip RAM; ports clock, reset (async active-low), s_axi AW/W/B/AR/R channels, AxLOCK/CACHE/PROT/QOS ignored
module gpgpu_axi_mem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH = 4,
  parameter int MEM_WORDS = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awlock,
  input  logic [3:0]              s_axi_awcache,
  input  logic [2:0]              s_axi_awprot,
  input  logic [3:0]              s_axi_awqos,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arlock,
  input  logic [3:0]              s_axi_arcache,
  input  logic [2:0]              s_axi_arprot,
  input  logic [3:0]              s_axi_arqos,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast
);
  localparam int SH = $clog2(DATA_WIDTH/8);
  localparam int IW = $clog2(MEM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(DATA_WIDTH/8);
  localparam logic [ADDR_WIDTH-SH-1:0] DEPTH = (ADDR_WIDTH-SH)'(MEM_WORDS);
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  w_state_t w_state, w_nxt;
  r_state_t r_state, r_nxt;
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic [ID_WIDTH-1:0] w_id;
  logic [ADDR_WIDTH-1:0] w_addr, w_off, r_addr, ld_addr, ld_off;
  logic [7:0] w_len, w_cnt, r_len, r_cnt;
  logic w_fixed, w_serr, w_err, w_err_nxt, w_ok, w_fin;
  logic r_fixed, r_serr, ld_fixed, ld_serr, ld_ok;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, ld, unused;
  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs = s_axi_wvalid & s_axi_wready;
  assign b_hs = s_axi_bvalid & s_axi_bready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;
  assign r_hs = s_axi_rvalid & s_axi_rready;
  assign w_off = w_addr - BASE_ADDR;
  assign w_ok = !w_serr && w_addr >= BASE_ADDR && w_off[ADDR_WIDTH-1:SH] < DEPTH;
  assign w_fin = w_cnt == w_len;
  // the read pipeline loads beat 0 straight from AR, later beats from the running pointer
  assign ld = ar_hs | (r_hs & !s_axi_rlast);
  assign ld_addr = r_state == R_IDLE ? s_axi_araddr : r_addr;
  assign ld_fixed = r_state == R_IDLE ? s_axi_arburst == 2'b00 : r_fixed;
  assign ld_serr = r_state == R_IDLE ? s_axi_arsize != 3'(SH) : r_serr;
  assign ld_off = ld_addr - BASE_ADDR;
  assign ld_ok = !ld_serr && ld_addr >= BASE_ADDR && ld_off[ADDR_WIDTH-1:SH] < DEPTH;
  assign unused = ^{w_off[SH-1:0], ld_off[SH-1:0], s_axi_awlock, s_axi_awcache, s_axi_awprot,
                    s_axi_awqos, s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos};
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_nxt;
      r_state <= r_nxt;
    end
  always_comb begin
    w_nxt = aw_hs ? W_DATA : (w_hs && w_fin) ? W_RESP : b_hs ? W_IDLE : w_state;
    r_nxt = ar_hs ? R_DATA : (r_hs && s_axi_rlast) ? R_IDLE : r_state;
    // response error is sticky over the burst; wlast only contributes to the error, never ends the burst
    w_err_nxt = aw_hs ? s_axi_awsize != 3'(SH) : w_hs ? w_err | !w_ok | (s_axi_wlast != w_fin) : w_err;
  end
  always_ff @(posedge clock)
    for (int b = 0; b < DATA_WIDTH/8; b++)
      if (w_hs && w_ok && s_axi_wstrb[b]) mem[w_off[SH+IW-1:SH]][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      s_axi_awready <= 1'b0;
      s_axi_wready <= 1'b0;
      s_axi_bvalid <= 1'b0;
      s_axi_bid <= '0;
      s_axi_bresp <= 2'b00;
      s_axi_arready <= 1'b0;
      s_axi_rvalid <= 1'b0;
      s_axi_rid <= '0;
      s_axi_rdata <= '0;
      s_axi_rresp <= 2'b00;
      s_axi_rlast <= 1'b0;
      w_id <= '0;
      w_addr <= '0;
      w_len <= '0;
      w_cnt <= '0;
      w_fixed <= 1'b0;
      w_serr <= 1'b0;
      w_err <= 1'b0;
      r_addr <= '0;
      r_len <= '0;
      r_cnt <= '0;
      r_fixed <= 1'b0;
      r_serr <= 1'b0;
    end else begin
      s_axi_awready <= w_nxt == W_IDLE;
      s_axi_wready <= w_nxt == W_DATA;
      s_axi_bvalid <= w_nxt == W_RESP;
      s_axi_bid <= w_nxt == W_RESP ? w_id : '0;
      s_axi_bresp <= {w_nxt == W_RESP && w_err_nxt, 1'b0};
      s_axi_arready <= r_nxt == R_IDLE;
      s_axi_rvalid <= r_nxt == R_DATA;
      w_err <= w_err_nxt;
      if (aw_hs) begin
        w_id <= s_axi_awid;
        w_addr <= s_axi_awaddr;
        w_len <= s_axi_awlen;
        w_cnt <= '0;
        w_fixed <= s_axi_awburst == 2'b00;
        w_serr <= s_axi_awsize != 3'(SH);
      end
      if (w_hs) begin
        w_cnt <= w_cnt + 8'd1;
        w_addr <= w_fixed ? w_addr : w_addr + STEP;
      end
      if (ar_hs) begin
        s_axi_rid <= s_axi_arid;
        s_axi_rlast <= s_axi_arlen == 8'd0;
        r_len <= s_axi_arlen;
        r_cnt <= '0;
        r_fixed <= s_axi_arburst == 2'b00;
        r_serr <= s_axi_arsize != 3'(SH);
      end
      if (r_hs) begin
        r_cnt <= r_cnt + 8'd1;
        s_axi_rlast <= !s_axi_rlast && r_cnt + 8'd1 == r_len;
      end
      if (ld) begin
        s_axi_rdata <= ld_ok ? mem[ld_off[SH+IW-1:SH]] : '0;
        s_axi_rresp <= ld_ok ? 2'b00 : 2'b10;
        r_addr <= ld_fixed ? ld_addr : ld_addr + STEP;
      end
    end
endmodule
